// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - register offsets, TCON bit positions, FSM states and priority helper for irq_ctrl
package irq_pkg;

    localparam int NSRC_DEFAULT = 4;

    // Word offsets as decoded from per_addr[4:2]
    localparam logic [2:0] OFF_TH     = 3'd0;
    localparam logic [2:0] OFF_TL     = 3'd1;
    localparam logic [2:0] OFF_TCON   = 3'd2;
    localparam logic [2:0] OFF_IMASK  = 3'd3;
    localparam logic [2:0] OFF_IPEND  = 3'd4;
    localparam logic [2:0] OFF_ICAUSE = 3'd5;

    localparam int TCON_EN   = 0;
    localparam int TCON_IE   = 1;
    localparam int TCON_PEND = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        lowest_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_index = 3'(i);
        end
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - peripheral bus bundle between the CPU data path and irq_ctrl
interface irq_ctrl_if;

    logic        per_rd;
    logic        per_wr;
    logic [31:0] per_addr;
    logic [31:0] per_wdata;
    logic [31:0] per_rdata;

    modport master (
        output per_rd,
        output per_wr,
        output per_addr,
        output per_wdata,
        input  per_rdata
    );

    modport slave (
        input  per_rd,
        input  per_wr,
        input  per_addr,
        input  per_wdata,
        output per_rdata
    );

endinterface

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - TH/TL/TCON system timer with reload and overflow pulse
module irq_timer
    import irq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [1:0]  tcon,
    output logic        ovf
);

    logic wrap;

    assign wrap = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    assign ovf  = wrap && tcon[TCON_IE];

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th)   th   <= wdata;
            if (wr_tcon) tcon <= wdata[1:0];
            // Software write to TL beats both reload and increment
            if (wr_tl)
                tl <= wdata;
            else if (wrap)
                tl <= th;
            else if (tcon[TCON_EN])
                tl <= tl + 32'd1;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller with optional system timer (IRQ_TIMER_EN) for the MIPS pipeline
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC = NSRC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] src_irq,
    input  logic            kernel_mode,
    input  logic            irq_ack,
    input  logic            irq_ret,
    output logic            irq,
    output logic [2:0]      irq_cause
);

    logic [2:0]      reg_sel;
    logic            wr_imask;
    logic            wr_ipend;
    logic [31:0]     th;
    logic [31:0]     tl;
    logic [1:0]      tcon;
    logic            tmr_ovf;
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;
    logic [NSRC-1:0] sync3;
    logic [NSRC-1:0] src_edge;
    logic [NSRC:0]   imask;
    logic [NSRC:0]   ipend;
    logic [NSRC:0]   ipend_set;
    logic [NSRC:0]   ipend_clr;
    logic [NSRC:0]   active;
    logic [2:0]      winner;
    logic [31:0]     rdata;
    state_t          state;
    logic            unused_bits;

    assign reg_sel  = bus.per_addr[4:2];
    assign wr_imask = bus.per_wr && (reg_sel == OFF_IMASK);
    assign wr_ipend = bus.per_wr && (reg_sel == OFF_IPEND);

`ifdef IRQ_TIMER_EN
    irq_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (bus.per_wr && (reg_sel == OFF_TH)),
        .wr_tl   (bus.per_wr && (reg_sel == OFF_TL)),
        .wr_tcon (bus.per_wr && (reg_sel == OFF_TCON)),
        .wdata   (bus.per_wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .ovf     (tmr_ovf)
    );
`else
    assign th      = '0;
    assign tl      = '0;
    assign tcon    = '0;
    assign tmr_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= src_irq;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign src_edge  = sync2 & ~sync3;
    assign ipend_set = {src_edge, tmr_ovf};
    assign ipend_clr = wr_ipend ? bus.per_wdata[NSRC:0] : '0;

    // Set is OR-ed in after the clear so a same-cycle edge is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            imask <= '0;
            ipend <= '0;
        end else begin
            if (wr_imask) imask <= bus.per_wdata[NSRC:0];
            ipend <= (ipend & ~ipend_clr) | ipend_set;
        end
    end

    assign active = ipend & imask;
    assign winner = lowest_index(8'(active));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            irq_cause <= 3'd0;
        end else begin
            case (state)
                IDLE: if ((|active) && !kernel_mode) state <= REQ;
                REQ: begin
                    if (active == '0) begin
                        state <= IDLE;
                    end else if (irq_ack) begin
                        irq_cause <= winner;
                        state     <= SVC;
                    end
                end
                SVC:     if (irq_ret) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign irq = (state == REQ);

    always_comb begin
        rdata = '0;
        if (bus.per_rd) begin
            case (reg_sel)
                OFF_TH:     rdata = th;
                OFF_TL:     rdata = tl;
                OFF_TCON:   rdata = {29'd0, ipend[0], tcon};
                OFF_IMASK:  rdata = 32'(imask);
                OFF_IPEND:  rdata = 32'(ipend);
                OFF_ICAUSE: rdata = {29'd0, irq_cause};
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.per_rdata = rdata;

    assign unused_bits = ^{bus.per_addr[31:5], bus.per_addr[1:0], bus.per_wdata};

endmodule
